// File: rtl/twi_pkg.sv
// Shared types and defaults for the TWI register controller.
package twi_pkg;

  localparam int TWI_NREGS = 8;
  localparam int TWI_DW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PTR   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } twi_state_t;

endpackage

// File: rtl/twi_reg_bank.sv
// Register storage with a single write port and flat read-out.
module twi_reg_bank
  import twi_pkg::*;
#(
  parameter int NREGS = TWI_NREGS,
  parameter int AW    = 3
) (
  input  logic                    clk_16mhz,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [TWI_DW-1:0]       i_wdata,
  output logic [TWI_DW*NREGS-1:0] o_reg_q
);

  logic [TWI_DW-1:0] r_regs [NREGS];

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign o_reg_q[TWI_DW*g +: TWI_DW] = r_regs[g];
  end

endmodule

// File: rtl/twi_reg_ctrl.sv
// TWI slave register controller: pointer FSM plus local-port arbitration.
// Define TWI_REG_WRITE_PROTECT_EN to make reg[0] bit 0 lock TWI writes to reg[1..].
module twi_reg_ctrl
  import twi_pkg::*;
#(
  parameter int NREGS = TWI_NREGS,
  parameter int AW    = 3
) (
  input  logic                    clk_16mhz,
  input  logic                    rst,
  input  logic                    twi_start,
  input  logic                    twi_rw,
  input  logic                    twi_stop,
  input  logic                    twi_wr_valid,
  input  logic [TWI_DW-1:0]       twi_wr_data,
  input  logic                    twi_rd_req,
  output logic                    twi_rd_valid,
  output logic [TWI_DW-1:0]       twi_rd_data,
  input  logic                    loc_req,
  input  logic                    loc_we,
  input  logic [AW-1:0]           loc_addr,
  input  logic [TWI_DW-1:0]       loc_wdata,
  output logic                    loc_gnt,
  output logic [TWI_DW-1:0]       loc_rdata,
  output logic [TWI_DW*NREGS-1:0] reg_q,
  output logic                    busy
);

  twi_state_t        r_state, w_state_nxt;
  logic [AW-1:0]     r_ptr, w_ptr_nxt;
  logic [TWI_DW-1:0] w_regs [NREGS];
  logic              w_no_frame, w_twi_wr, w_twi_rd, w_lock, w_we;

  for (genvar g = 0; g < NREGS; g++) begin : g_unflat
    assign w_regs[g] = reg_q[TWI_DW*g +: TWI_DW];
  end

  // Data-phase strobes coinciding with START/STOP are dropped.
  assign w_no_frame = !twi_start && !twi_stop;
  assign w_twi_wr   = (r_state == ST_WDATA) && twi_wr_valid && w_no_frame;
  assign w_twi_rd   = (r_state == ST_RDATA) && twi_rd_req && w_no_frame;

`ifdef TWI_REG_WRITE_PROTECT_EN
  assign w_lock = w_regs[0][0] && (r_ptr != '0);
`else
  assign w_lock = 1'b0;
`endif

  assign loc_gnt   = loc_req && !w_twi_wr && !w_twi_rd && !rst;
  assign loc_rdata = loc_gnt ? w_regs[loc_addr] : '0;
  assign w_we      = (w_twi_wr && !w_lock) || (loc_gnt && loc_we);
  assign busy      = (r_state != ST_IDLE) && !rst;

  twi_reg_bank #(.NREGS(NREGS), .AW(AW)) u_bank (
    .clk_16mhz (clk_16mhz),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_twi_wr ? r_ptr : loc_addr),
    .i_wdata   (w_twi_wr ? twi_wr_data : loc_wdata),
    .o_reg_q   (reg_q)
  );

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      twi_rd_valid <= 1'b0;
      twi_rd_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      twi_rd_valid <= twi_rd_req;
      if (twi_rd_req) twi_rd_data <= w_twi_rd ? w_regs[r_ptr] : 8'hFF;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (twi_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (twi_start) begin
      w_state_nxt = twi_rw ? ST_RDATA : ST_PTR;
    end else begin
      case (r_state)
        ST_PTR: begin
          if (twi_wr_valid) begin
            w_ptr_nxt   = twi_wr_data[AW-1:0];
            w_state_nxt = ST_WDATA;
          end
        end
        ST_WDATA: if (twi_wr_valid) w_ptr_nxt = r_ptr + 1'b1;
        ST_RDATA: if (twi_rd_req)   w_ptr_nxt = r_ptr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
